// File: rtl/fb_draw_pkg.sv
// fb_draw_pkg: shared FSM state type and framebuffer size helpers for fb_draw_arbiter
package fb_draw_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_OWN} state_t;

    function automatic int fb_npix(input int w, input int h);
        return w * h;
    endfunction

    function automatic int fb_addrw(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/fb_draw_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set req at or above ptr (wrapping) -> one-hot
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] j;

    // scan from the far end so the candidate closest to ptr overwrites the rest
    always_comb begin
        gnt = '0;
        j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_draw_arbiter.sv
// fb_draw_arbiter: round-robin framebuffer write-port arbiter; clear pass built only with FB_CLEAR_EN
module fb_draw_arbiter import fb_draw_pkg::*; #(
    parameter int NREQ      = 4,
    parameter int CORDW     = 9,
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int DATAW     = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      frame,
    input  logic [DATAW-1:0]                          clear_cidx,
    input  logic [NREQ-1:0]                           req,
    input  logic [NREQ-1:0]                           drawing,
    input  logic [NREQ-1:0]                           done,
    input  logic [NREQ*CORDW-1:0]                     px,
    input  logic [NREQ*CORDW-1:0]                     py,
    input  logic [NREQ*DATAW-1:0]                     cidx,
    output logic [NREQ-1:0]                           grant,
    output logic                                      fb_we,
    output logic [fb_addrw(FB_WIDTH, FB_HEIGHT)-1:0]  fb_addr,
    output logic [DATAW-1:0]                          fb_cidx,
    output logic                                      busy
);
    localparam int IW   = $clog2(NREQ);
    localparam int AW   = fb_addrw(FB_WIDTH, FB_HEIGHT);
    localparam int NPIX = fb_npix(FB_WIDTH, FB_HEIGHT);

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, own, pick_idx;
    logic [NREQ-1:0]   grant_q, grant_d, pick;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATAW-1:0]  cidx_q, cidx_d;
    logic [CORDW-1:0]  opx, opy;
    logic [DATAW-1:0]  ocidx;
    logic              clr_go, clr_last;
    logic [AW-1:0]     clr_addr;

    rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(ptr_q), .gnt(pick));

`ifdef FB_CLEAR_EN
    logic          clr_pend_q, clr_pend_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    // a frame seen while a client owns the port waits for its done; IDLE consumes it
    always_comb begin
        clr_pend_d = (state_q == ST_OWN) & (clr_pend_q | frame);
        clr_addr_d = (state_q == ST_CLEAR) ? clr_addr_q + 1'b1 : '0;
    end

    // clear-pass bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_pend_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_pend_q <= clr_pend_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clr_go   = clr_pend_q | frame;
    assign clr_addr = clr_addr_q;
    assign clr_last = clr_addr_q == AW'(NPIX - 1);
`else
    logic unused_frame;

    assign unused_frame = frame;
    assign clr_go       = 1'b0;
    assign clr_addr     = '0;
    assign clr_last     = 1'b1;
`endif

    // owner is the index just below the search pointer; also decode the picked index
    always_comb begin
        own      = (ptr_q == '0) ? IW'(NREQ - 1) : ptr_q - 1'b1;
        pick_idx = '0;
        opx      = '0;
        opy      = '0;
        ocidx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
            if (own == IW'(i)) begin
                opx   = px[i*CORDW +: CORDW];
                opy   = py[i*CORDW +: CORDW];
                ocidx = cidx[i*DATAW +: DATAW];
            end
        end
    end

    // next state, grant and registered write port
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        cidx_d  = cidx_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_go) begin
                    state_d = ST_CLEAR;
                end else if (|req) begin
                    state_d = ST_OWN;
                    grant_d = pick;
                    ptr_d   = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_CLEAR: begin
                we_d    = 1'b1;
                addr_d  = clr_addr;
                cidx_d  = clear_cidx;
                state_d = clr_last ? ST_IDLE : ST_CLEAR;
            end
            ST_OWN: begin
                if (drawing[own] && 32'(opx) < 32'(FB_WIDTH) && 32'(opy) < 32'(FB_HEIGHT)) begin
                    we_d   = 1'b1;
                    addr_d = AW'(32'(opy) * 32'(FB_WIDTH) + 32'(opx));
                    cidx_d = ocidx;
                end
                if (done[own]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and output registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cidx_q  <= cidx_d;
        end
    end

    assign grant   = grant_q;
    assign fb_we   = we_q;
    assign fb_addr = addr_q;
    assign fb_cidx = cidx_q;
    assign busy    = state_q != ST_IDLE;
endmodule

// File: doc/fb_draw_arbiter.md
FB_DRAW_ARBITER -- requirements
Module: fb_draw_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of drawing clients (2..8).
REQ-002 SHALL have parameter CORDW, default 9, client coordinate width in bits.
REQ-003 SHALL have parameter FB_WIDTH, default 320, framebuffer width in pixels.
REQ-004 SHALL have parameter FB_HEIGHT, default 240, framebuffer height in pixels.
REQ-005 SHALL have parameter DATAW, default 4, colour index width in bits.
REQ-006 SHALL have ports, listed as name  direction  width  meaning:
- clk  in  1  clock; one clock, all logic on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- frame  in  1  one-cycle start-of-frame pulse (vertical blanking start).
- clear_cidx  in  DATAW  colour index written by the clear pass.
- req  in  NREQ  client i requests the write port.
- drawing  in  NREQ  client i pixel valid this cycle.
- done  in  NREQ  client i one-cycle shape-complete pulse.
- px, py  in  NREQ*CORDW each  packed client pixel coordinates.
- cidx  in  NREQ*DATAW  packed client colour indices.
- grant  out  NREQ  one-hot grant; drives client oe.
- fb_we  out  1  framebuffer write enable.
- fb_addr  out  $clog2(FB_WIDTH*FB_HEIGHT)  framebuffer write address.
- fb_cidx  out  DATAW  framebuffer write data.
- busy  out  1  clear pass active or a grant held.

Function
REQ-007 SHALL implement FSM states IDLE, CLEAR, OWN.
REQ-008 SHALL in IDLE with any req bit set and no clear pending assert one grant bit on the next cycle and enter OWN.
REQ-009 SHALL choose the grant round-robin, searching upward from (last granted index + 1) mod NREQ; after reset the search starts at index 0.
REQ-010 SHALL hold grant unchanged in OWN until done of the owner is seen, then drop grant the next cycle and return to IDLE; no grant in that same cycle.
REQ-011 SHALL ignore req, drawing and done of non-owners; grant never has more than one bit set.
REQ-012 SHALL compute fb_addr = py*FB_WIDTH + px of the owner, registered; fb_we, fb_addr and fb_cidx are valid one cycle after the owner's drawing is high.
REQ-013 SHALL suppress fb_we (force 0) when the owner's px >= FB_WIDTH or py >= FB_HEIGHT.
REQ-014 SHALL with req deasserted by the owner mid-shape keep the grant until done (req is only sampled in IDLE).
REQ-015 SHALL with done and drawing both high on the owner in one cycle still write that pixel.

Reset
REQ-016 SHALL on rst_n low immediately set state IDLE, grant 0, fb_we 0, fb_addr 0, fb_cidx 0, busy 0, clear pending 0, round-robin pointer 0.
REQ-017 SHALL on reset mid-shape or mid-clear abandon the operation; no resume after release.

Configuration
REQ-018 SHALL compile the clear pass in only when FB_CLEAR_EN is defined.
REQ-019 SHALL with FB_CLEAR_EN set clear pending on frame; from IDLE enter CLEAR, writing clear_cidx to addresses 0..FB_WIDTH*FB_HEIGHT-1, one per cycle, fb_we high, then return to IDLE.
REQ-020 SHALL with FB_CLEAR_EN keep a frame arriving in OWN pending until the owner's done; frame during CLEAR is ignored.
REQ-021 SHALL without FB_CLEAR_EN ignore frame and clear_cidx; state CLEAR unreachable.

Structure
REQ-022 SHALL place the state enum and the pixel-count/address-width helper in package fb_draw_pkg.
REQ-023 SHALL use one sub-module, rr_pick, the combinational round-robin selector (req, pointer -> one-hot).

Verification
REQ-024 SHALL cover: req=4'b0101 after reset -> grant 0001; after done -> grant 0100; next -> 0001.
REQ-025 SHALL cover: owner draws px=10, py=2 -> one cycle later fb_we=1, fb_addr=650.
REQ-026 SHALL cover: owner px=320, py=0 with drawing=1 -> fb_we stays 0.
REQ-027 SHALL cover: FB_CLEAR_EN, frame in IDLE -> 76800 consecutive writes, addresses 0..76799, then grant resumes.
REQ-028 SHALL cover: FB_CLEAR_EN, frame while client 2 owns -> clear starts only after client 2's done.
REQ-029 SHALL cover: rst_n low mid-shape -> grant 0 and fb_we 0 immediately, without waiting for a clock edge.
